// File: rtl/sub_result_fifo.sv
// Result buffer behind the sub-result producer: drops all-lanes-off entries and counts them.
// Optional per-entry parity output enabled by defining SUB_RESULT_FIFO_PARITY_EN.
module sub_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int SUB_W  = 3,
    parameter int LANE_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SUB_W-1:0]          in_sub,
    input  logic [SUB_W-1:0]          in_extra,
    input  logic [LANE_W-1:0]         in_lane_l,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SUB_W-1:0]          out_sub,
    output logic [SUB_W-1:0]          out_extra,
    output logic [LANE_W-1:0]         out_lane,
    output logic [$clog2(DEPTH):0]    out_count,
`ifdef SUB_RESULT_FIFO_PARITY_EN
    output logic                      out_par,
`endif
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      drop_clr
);
    localparam int AW   = $clog2(DEPTH);
    localparam int ENT_W = 2 * SUB_W + LANE_W;
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
    localparam logic [AW:0]    CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]    CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_ZERO  = (AW + 1)'(0);
    localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

    function automatic logic even_par(input logic [ENT_W-1:0] data);
        return ^data;
    endfunction

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [AW:0]      count_r, count_nxt_s;
    logic [ENT_W-1:0] wdata_s, head_s;
    logic             out_valid_r;
    logic [ENT_W-1:0] out_data_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             accept_s, push_s, drop_s, pop_s, head_is_new_s;

    assign in_ready = reset_l && (count_r != CNT_FULL);
    assign accept_s = in_valid && in_ready;
    assign push_s   = accept_s && !(&in_lane_l);
    assign drop_s   = accept_s && (&in_lane_l);
    assign pop_s    = out_valid_r && out_ready;
    assign wdata_s  = {in_sub, in_extra, ~in_lane_l};

    // Next count/read pointer and the entry that will sit at the head after this edge
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // Pointers only coincide on a push when the FIFO is empty after the pop
        head_is_new_s = push_s && (wr_ptr_r == rd_ptr_nxt_s);
        if (head_is_new_s) begin
            head_s = wdata_s;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // Pointers, occupancy and registered head presentation
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != CNT_ZERO);
            out_data_r  <= (count_nxt_s != CNT_ZERO) ? head_s : '0;
        end
    end

    // Saturating drop counter; clear wins over a simultaneous drop
    always_ff @(posedge clk) begin
        if (!reset_l || drop_clr) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != DROP_MAX)) begin
            drop_cnt_r <= drop_cnt_r + DROP_ONE;
        end
    end

`ifdef SUB_RESULT_FIFO_PARITY_EN
    logic par_mem_r [DEPTH];
    logic out_par_r, head_par_s;

    assign head_par_s = head_is_new_s ? even_par(wdata_s) : par_mem_r[rd_ptr_nxt_s];

    // Parity captured alongside each pushed entry
    always_ff @(posedge clk) begin
        if (push_s) begin
            par_mem_r[wr_ptr_r] <= even_par(wdata_s);
        end
    end

    // Head parity, zero whenever the head is not valid
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            out_par_r <= 1'b0;
        end else begin
            out_par_r <= (count_nxt_s != CNT_ZERO) ? head_par_s : 1'b0;
        end
    end

    assign out_par = out_par_r;
`endif

    assign out_valid = out_valid_r;
    assign {out_sub, out_extra, out_lane} = out_data_r;
    assign out_count = count_r;
    assign drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_sub_result_fifo.sv
// Directed self-checking bench for sub_result_fifo (default parameters).
module tb_sub_result_fifo;
    logic       clk;
    logic       reset_l;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sub;
    logic [2:0] in_extra;
    logic [3:0] in_lane_l;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sub;
    logic [2:0] out_extra;
    logic [3:0] out_lane;
    logic [2:0] out_count;
    logic [7:0] drop_cnt;
    logic       drop_clr;
`ifdef SUB_RESULT_FIFO_PARITY_EN
    logic       out_par;
`endif

    int checks = 0;
    int errors = 0;

    sub_result_fifo dut (
        .clk(clk), .reset_l(reset_l),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .in_extra(in_extra), .in_lane_l(in_lane_l),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sub(out_sub), .out_extra(out_extra), .out_lane(out_lane),
        .out_count(out_count),
`ifdef SUB_RESULT_FIFO_PARITY_EN
        .out_par(out_par),
`endif
        .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] val, input logic [3:0] lane_l);
        in_valid  = v;
        in_extra  = val[5:3];
        in_sub    = val[2:0];
        in_lane_l = lane_l;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        drive(1'b1, 6'd7, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready cyc %0d got %b want 0", i, in_ready);
            end
        end
        drive(1'b0, 6'd0, 4'h0);
        reset_l = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if ({out_valid, out_count, drop_cnt, out_sub, out_extra, out_lane} !== 22'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b c=%0d d=%0d s=%h e=%h l=%h want all 0",
                     out_valid, out_count, drop_cnt, out_sub, out_extra, out_lane);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_sub = 3'h5; in_extra = 3'h2; in_lane_l = 4'hA;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_sub, out_extra, out_lane, out_count} !== {1'b1, 3'h5, 3'h2, 4'h5, 3'd1}) begin
            errors++;
            $display("FAIL single_head got v=%b s=%h e=%h l=%h c=%0d want 1 5 2 5 1",
                     out_valid, out_sub, out_extra, out_lane, out_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, out_sub, out_extra, out_lane, out_count} !== 14'h0) begin
            errors++;
            $display("FAIL single_pop got v=%b s=%h e=%h l=%h c=%0d want all 0",
                     out_valid, out_sub, out_extra, out_lane, out_count);
        end
    endtask

    task automatic test_fill_wrap();
        int next_in;
        int exp;
        logic acc;
        logic pop;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 6'(i), 4'h0);
            tick();
        end
        checks++;
        if ({in_ready, out_count} !== {1'b0, 3'd4}) begin
            errors++;
            $display("FAIL full_flags got rdy=%b c=%0d want 0 4", in_ready, out_count);
        end
        drive(1'b1, 6'd5, 4'h0);
        tick();
        checks++;
        if ({out_count, out_extra, out_sub} !== {3'd4, 6'd1}) begin
            errors++;
            $display("FAIL full_reject got c=%0d head=%0d want 4 1", out_count, {out_extra, out_sub});
        end
        out_ready = 1'b1;
        next_in = 5;
        exp = 1;
        for (int cyc = 0; cyc < 100 && exp <= 12; cyc++) begin
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                checks++;
                if ({out_extra, out_sub} !== 6'(exp)) begin
                    errors++;
                    $display("FAIL stream_order got %0d want %0d", {out_extra, out_sub}, exp);
                end
                exp++;
            end
            tick();
            if (acc) next_in++;
            if (next_in > 12) drive(1'b0, 6'd0, 4'h0);
            else drive(1'b1, 6'(next_in), 4'h0);
            if (out_count > 3'd4) begin
                errors++;
                $display("FAIL stream_count got %0d want <=4", out_count);
            end
        end
        checks++;
        if (exp != 13) begin
            errors++;
            $display("FAIL stream_timeout got %0d pops want 12", exp - 1);
        end
        out_ready = 1'b0;
        checks++;
        if ({out_valid, out_count} !== 4'h0) begin
            errors++;
            $display("FAIL stream_empty got v=%b c=%0d want 0 0", out_valid, out_count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 6'd1, 4'h0); tick();
        drive(1'b1, 6'd2, 4'h0); tick();
        out_ready = 1'b1;
        for (int i = 3; i <= 4; i++) begin
            drive(1'b1, 6'(i), 4'h0);
            tick();
            checks++;
            if ({out_count, out_extra, out_sub} !== {3'd2, 6'(i - 1)}) begin
                errors++;
                $display("FAIL pushpop_%0d got c=%0d head=%0d want 2 %0d", i, out_count, {out_extra, out_sub}, i - 1);
            end
        end
        drive(1'b0, 6'd0, 4'h0);
        tick();
        checks++;
        if ({out_count, out_extra, out_sub} !== {3'd1, 6'd4}) begin
            errors++;
            $display("FAIL pushpop_drain got c=%0d head=%0d want 1 4", out_count, {out_extra, out_sub});
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_drop();
        drive(1'b1, 6'd9, 4'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd6, 4'hF);
            tick();
        end
        checks++;
        if ({drop_cnt, out_count, out_extra, out_sub} !== {8'd3, 3'd1, 6'd9}) begin
            errors++;
            $display("FAIL drop_count got d=%0d c=%0d head=%0d want 3 1 9", drop_cnt, out_count, {out_extra, out_sub});
        end
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        drive(1'b0, 6'd0, 4'h0);
        checks++;
        if ({drop_cnt, out_count} !== {8'd0, 3'd1}) begin
            errors++;
            $display("FAIL drop_clr got d=%0d c=%0d want 0 1", drop_cnt, out_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 6'(i + 20), 4'h3);
            tick();
        end
        drive(1'b0, 6'd0, 4'h0);
        checks++;
        if (out_count !== 3'd3) begin
            errors++;
            $display("FAIL midrst_fill got %0d want 3", out_count);
        end
        reset_l = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, out_count, out_sub, out_extra, out_lane} !== 15'h0) begin
            errors++;
            $display("FAIL midrst_clear got rdy=%b v=%b c=%0d s=%h e=%h l=%h want all 0",
                     in_ready, out_valid, out_count, out_sub, out_extra, out_lane);
        end
        reset_l = 1'b1;
        in_valid = 1'b1; in_sub = 3'h5; in_extra = 3'h2; in_lane_l = 4'hA;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_count, out_sub, out_extra, out_lane} !== {1'b1, 3'd1, 3'h5, 3'h2, 4'h5}) begin
            errors++;
            $display("FAIL midrst_head got v=%b c=%0d s=%h e=%h l=%h want 1 1 5 2 5",
                     out_valid, out_count, out_sub, out_extra, out_lane);
        end
`ifdef SUB_RESULT_FIFO_PARITY_EN
        // {101,010,0101} holds five set bits, so the XOR is 1
        checks++;
        if (out_par !== 1'b1) begin
            errors++;
            $display("FAIL parity got %b want 1", out_par);
        end
`endif
    endtask

    initial begin
        reset_l = 1'b0; drop_clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 6'd0, 4'h0);
        test_reset();
        test_single();
        test_fill_wrap();
        test_back_to_back();
        test_drop();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
